// File: rtl/moving_average3_inverse.sv
// Inverse of a 3-tap moving average: x[n] = 3*y[n] - x[n-1] - x[n-2], one-cycle latency.
// Define MOVING_AVERAGE3_INVERSE_SAT_EN to clip results to the signed WIDTH range (else wrap).
module moving_average3_inverse #(
    parameter int WIDTH = 8
) (
    input  logic                    system1000,
    input  logic                    system1000_rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_primed,
    output logic                    sat_o,
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] h1_q, h2_q;
    logic signed [WIDTH-1:0] h1_eff, h2_eff;
    logic signed [WIDTH-1:0] res_d;
    logic                    clip_d;
    logic                    primed_d;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] out_data_q;
    logic                    out_primed_q;

    // State register
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q <= FILL0;
        end else if (in_valid) begin
            state_q <= state_d;
        end
    end

    // Next state: one step per accepted sample, RUN absorbing
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL0:   state_d = FILL1;
            FILL1:   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = FILL0;
        endcase
    end

    // FSM outputs: history is untrusted until two samples have been seen
    always_comb begin
        h1_eff   = h1_q;
        h2_eff   = h2_q;
        primed_d = 1'b0;
        case (state_q)
            FILL0: begin
                h1_eff = '0;
                h2_eff = '0;
            end
            RUN:     primed_d = 1'b1;
            default: primed_d = 1'b0;
        endcase
    end

`ifdef MOVING_AVERAGE3_INVERSE_SAT_EN
    localparam logic signed [WIDTH+2:0] T_MAX = (WIDTH+3)'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [WIDTH+2:0] T_MIN = (WIDTH+3)'(-(2 ** (WIDTH - 1)));

    logic signed [WIDTH+2:0] y_x, t;
    logic                    sat_q;

    // Three extra bits hold 3*y minus two full-range history values without overflow
    always_comb begin
        y_x    = (WIDTH+3)'(in_data);
        t      = (y_x <<< 1) + y_x - (WIDTH+3)'(h1_eff) - (WIDTH+3)'(h2_eff);
        res_d  = t[WIDTH-1:0];
        clip_d = 1'b0;
        if (t > T_MAX) begin
            res_d  = T_MAX[WIDTH-1:0];
            clip_d = 1'b1;
        end else if (t < T_MIN) begin
            res_d  = T_MIN[WIDTH-1:0];
            clip_d = 1'b1;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= in_valid & clip_d;
        end
    end

    assign sat_o = sat_q;
`else
    // Modular WIDTH-bit arithmetic yields exactly the low WIDTH bits of the wide sum
    always_comb begin
        res_d  = (in_data <<< 1) + in_data - h1_eff - h2_eff;
        clip_d = 1'b0;
    end

    assign sat_o = clip_d;
`endif

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            h1_q         <= '0;
            h2_q         <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_primed_q <= 1'b0;
        end else if (in_valid) begin
            h2_q         <= h1_eff;
            h1_q         <= res_d;
            out_valid_q  <= 1'b1;
            out_data_q   <= res_d;
            out_primed_q <= primed_d;
        end else begin
            out_valid_q  <= 1'b0;
            out_primed_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_primed  = out_primed_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/moving_average3_inverse.md
MOVING_AVERAGE3_INVERSE -- requirements
Module: moving_average3_inverse

Interface
REQ-001 Parameter WIDTH, default 8: signed sample width of in_data and out_data.
REQ-002 system1000  input  1  clock; all state updates on its rising edge.
REQ-003 system1000_rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  in_data carries a new 3-tap moving-average sample this cycle.
REQ-005 in_data  input  WIDTH signed  moving-average sample y[n].
REQ-006 out_valid  output  1  out_data carries a reconstructed sample this cycle.
REQ-007 out_data  output  WIDTH signed  reconstructed sample x[n].
REQ-008 out_primed  output  1  high when out_data derives from two prior accepted samples.
REQ-009 sat_o  output  1  one-cycle pulse alongside out_valid when out_data was clipped.
REQ-010 The clocking is decided: one clock; reset is synchronous and active-high.

Function
REQ-011 The block SHALL invert the 3-tap moving average: t = 3*y[n] - h1 - h2, where h1 and h2 are the two previous out_data values.
REQ-012 t SHALL be computed at WIDTH+3 signed bits with no intermediate overflow.
REQ-013 Latency SHALL be exactly 1 cycle: a sample accepted in cycle k gives out_valid=1 in cycle k+1.
REQ-014 in_valid=0 SHALL give out_valid=0 the next cycle; h1, h2, out_data and state SHALL hold.
REQ-015 On each accepted sample: h2 <= h1, h1 <= new out_data (the post-clip/wrap value).
REQ-016 There is no back-pressure; every cycle with in_valid=1 SHALL be accepted.
REQ-017 The fill FSM SHALL have states FILL0, FILL1 and RUN, advancing one state per accepted sample, with RUN absorbing.
REQ-018 out_primed SHALL be registered alongside out_valid and be 1 only for samples accepted while in RUN.
REQ-019 Uncertain history SHALL be treated as zero: h1 = h2 = 0 in FILL0.
REQ-020 sat_o SHALL be 0 whenever out_valid is 0.

Reset
REQ-021 While system1000_rst=1 at a clock edge, out_valid, out_data, out_primed, sat_o, h1 and h2 SHALL go to 0 and the FSM SHALL go to FILL0.
REQ-022 Reset SHALL override a simultaneous in_valid; that sample SHALL be discarded.
REQ-023 Reset mid-stream SHALL drop all history; the first sample after reset SHALL be computed as in FILL0.

Configuration
REQ-024 With macro MOVING_AVERAGE3_INVERSE_SAT_EN defined, t SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1], and sat_o SHALL pulse whenever clipping occurs.
REQ-025 Without MOVING_AVERAGE3_INVERSE_SAT_EN, out_data SHALL be the low WIDTH bits of t (two's-complement wrap), and sat_o SHALL be tied 0.

Verification
REQ-026 Reset, then y=10 for four consecutive cycles -> out_data 30, 0, 0, 30; out_primed 0, 0, 1, 1.
REQ-027 Reset, then y=100 -> SAT_EN: out_data=127, sat_o=1; no SAT_EN: out_data=44, sat_o=0.
REQ-028 Reset, then y=-100 -> SAT_EN: out_data=-128, sat_o=1; no SAT_EN: out_data=-44.
REQ-029 y=10, then 3 idle cycles, then y=10 -> out_valid is high only in the 2 result cycles; outputs are 30 then 0 (history held across the gap).
REQ-030 In RUN, reset asserted together with in_valid (y=5), then y=5 -> first valid output after reset is 15 with out_primed=0.
